inst_fetcher: RTL and testbench

//  Fetch stage upstream of the instruction decoder. Generates sequential PCs,

---
 rtl/inst_fetcher.sv | 147 ++++++++++++++
 tb/tb_inst_fetcher.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Fetch stage: sequential PC generation, single-outstanding imem reads,
// and a small FIFO of {pc, inst} pairs presented to the decoder.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_valid/ready/addr         instruction read request (one in flight)
//   imem_rvalid/rdata             read response, one per accepted request
//   redirect/redirect_pc          flush FIFO and restart fetch at a new PC
//   if_valid/ready/pc/bits        FIFO head towards the decoder
module inst_fetcher #(
    parameter int                XLEN_P       = 64,
    parameter int                QUEUE_DEPTH  = 4,
    parameter logic [XLEN_P-1:0] RESET_VECTOR = XLEN_P'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_valid,
    input  logic              imem_ready,
    output logic [XLEN_P-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [XLEN_P-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN_P-1:0] if_pc,
    output logic [31:0]       if_bits
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [XLEN_P-1:0] fetch_pc;
    logic [XLEN_P-1:0] req_pc;
    logic [XLEN_P-1:0] pc_mem   [QUEUE_DEPTH];
    logic [31:0]       bits_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Set by reset, cleared by the first accepted request afterwards: a
    // response arriving in that window belongs to a pre-reset request.
    logic              rst_stale;

    logic              req_fire;
    logic              push;
    logic              pop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)   state_next = S_REQ;
                else if (redirect) state_next = S_DROP;
            end
            S_DROP: begin
                if (imem_rvalid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // Output logic. With nothing in flight in REQ, the credit check
    // reduces to count < QUEUE_DEPTH, so a push can never overflow.
    always_comb begin
        imem_valid = 1'b0;
        push       = 1'b0;
        unique case (state)
            S_REQ:   imem_valid = !rst && !redirect &&
                                  (count < CNT_W'(QUEUE_DEPTH));
            S_WAIT:  push = imem_rvalid && !redirect;
            default: ;
        endcase
    end

    assign req_fire  = imem_valid && imem_ready;
    assign pop       = if_valid && if_ready;
    assign imem_addr = fetch_pc;
    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? pc_mem[rd_ptr]   : '0;
    assign if_bits   = if_valid ? bits_mem[rd_ptr] : '0;

    // PC, pointers and occupancy; redirect wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_VECTOR;
            req_pc    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rst_stale <= 1'b1;
        end else begin
            if (req_fire) begin
                req_pc    <= fetch_pc;
                fetch_pc  <= fetch_pc + XLEN_P'(4);
                rst_stale <= 1'b0;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc & ~XLEN_P'(3);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: unoccupied slots are never presented.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= req_pc;
            bits_mem[wr_ptr] <= imem_rdata;
        end
    end

    // A response with no request in flight is a bus protocol violation.
    rvalid_in_req: assert property (
        @(posedge clk) disable iff (rst)
        !(state == S_REQ && imem_rvalid && !rst_stale)
    );

endmodule

// File: tb/tb_inst_fetcher.sv
// Testbench for inst_fetcher: scenario tasks driven against a memory
// responder and a queue-based model of the decoder-visible stream.
module tb_inst_fetcher;

    localparam int          D  = 4;
    localparam logic [63:0] RV = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_valid;
    logic        imem_ready;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_bits;

    int errors = 0;
    int checks = 0;

    // Model: PCs that must reach the decoder, in order.
    logic [63:0] m_q[$];
    logic [63:0] m_fetch;
    logic [63:0] m_out_pc;
    bit          m_out;
    bit          m_drop;

    // Memory responder
    bit          mem_auto;
    int          mem_lat;
    bit          p_v;
    int          p_cnt;
    logic [63:0] p_addr;

    logic [63:0] pops[$];

    inst_fetcher dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_ready(if_ready), .if_pc(if_pc), .if_bits(if_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[25:2], 8'h13};
    endfunction

    // One clock: check outputs against the model, advance the model by the
    // rules of the fetch stage, then let the memory drive its response.
    task automatic step();
        bit          hs;
        bit          pp;
        bit          rv;
        bit          exp_iv;
        logic [63:0] a;
        #1;
        if (!rst) begin
            checks++;
            if (if_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL step_if_valid: got %b want %b",
                         if_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (if_pc !== m_q[0] || if_bits !== mem_word(m_q[0])) begin
                    errors++;
                    $display("FAIL step_head: got %h/%h want %h/%h",
                             if_pc, if_bits, m_q[0], mem_word(m_q[0]));
                end
            end
        end
        exp_iv = !rst && !m_out && (m_q.size() < D) && !redirect;
        checks++;
        if (imem_valid !== exp_iv) begin
            errors++;
            $display("FAIL step_imem_valid: got %b want %b",
                     imem_valid, exp_iv);
        end
        if (exp_iv) begin
            checks++;
            if (imem_addr !== m_fetch) begin
                errors++;
                $display("FAIL step_imem_addr: got %h want %h",
                         imem_addr, m_fetch);
            end
        end
        hs = imem_valid && imem_ready;
        pp = if_valid && if_ready;
        rv = imem_rvalid;
        a  = imem_addr;
        if (rst) begin
            m_fetch = RV;
            m_out   = 0;
            m_drop  = 0;
            m_q.delete();
        end else begin
            if (pp && m_q.size() != 0) begin
                pops.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (rv && m_out) begin
                if (!m_drop && !redirect) m_q.push_back(m_out_pc);
                m_out  = 0;
                m_drop = 0;
            end
            if (hs) begin
                m_out    = 1;
                m_out_pc = m_fetch;
                m_fetch  = m_fetch + 64'd4;
            end
            if (redirect) begin
                m_q.delete();
                m_fetch = redirect_pc & ~64'd3;
                if (m_out) m_drop = 1;
            end
        end
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rvalid = 1'b0;
            if (rst) begin
                p_v = 0;
            end else begin
                if (p_v) p_cnt--;
                if (hs) begin
                    p_v    = 1;
                    p_addr = a;
                    p_cnt  = mem_lat - 1;
                end
                if (p_v && p_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(p_addr);
                    p_v         = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        step();
        step();
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 64'd0 || if_bits !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h/%h want 0/0/0",
                     if_valid, if_pc, if_bits);
        end
        checks++;
        if (imem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_imem_valid: got %b want 0", imem_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_valid !== 1'b1 || imem_addr !== RV) begin
            errors++;
            $display("FAIL reset_first_req: got %b/%h want 1/%h",
                     imem_valid, imem_addr, RV);
        end
    endtask

    task automatic test_stream();
        int n0;
        n0 = pops.size();
        imem_ready = 1'b1;
        if_ready   = 1'b1;
        mem_lat    = 1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (pops.size() - n0 < 8) begin
            errors++;
            $display("FAIL stream_throughput: got %0d want >=8",
                     pops.size() - n0);
        end else begin
            checks++;
            if (pops[n0] !== RV || pops[n0+1] !== RV + 64'd4) begin
                errors++;
                $display("FAIL stream_order: got %h,%h want %h,%h",
                         pops[n0], pops[n0+1], RV, RV + 64'd4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        int          n0;
        if_ready   = 1'b0;
        imem_ready = 1'b1;
        held       = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 12) held = if_pc;
        end
        #1;
        checks++;
        if (if_valid !== 1'b1 || imem_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got if_valid=%b imem_valid=%b want 1/0",
                     if_valid, imem_valid);
        end
        checks++;
        if (if_pc !== held) begin
            errors++;
            $display("FAIL bp_hold: got %h want %h", if_pc, held);
        end
        n0         = pops.size();
        if_ready   = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (pops.size() - n0 !== D) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d want %0d",
                     pops.size() - n0, D);
        end
    endtask

    task automatic test_push_pop();
        int n0;
        if_ready   = 1'b0;
        imem_ready = 1'b1;
        mem_lat    = 1;
        for (int i = 0; i < 12; i++) step();
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        step();
        if_ready = 1'b1;
        #1;
        checks++;
        if (imem_rvalid !== 1'b1 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL pp_setup: got rvalid=%b if_valid=%b want 1/1",
                     imem_rvalid, if_valid);
        end
        step();
        imem_ready = 1'b0;
        if_ready   = 1'b1;
        n0         = pops.size();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (pops.size() - n0 !== D - 1) begin
            errors++;
            $display("FAIL pp_count: got %0d want %0d",
                     pops.size() - n0, D - 1);
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit ok;
        if_ready   = 1'b1;
        imem_ready = 1'b1;
        mem_lat    = 3;
        found      = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            found = imem_valid && imem_ready;
            step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rw_no_request: got none want handshake");
        end
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0102;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (if_valid !== 1'b0 || imem_valid !== 1'b0) begin
                errors++;
                $display("FAIL rw_drop: got %b/%b want 0/0",
                         if_valid, imem_valid);
            end
            step();
        end
        ok = 0;
        for (int i = 0; i < 6 && !ok; i++) begin
            #1;
            ok = imem_valid;
            if (!ok) step();
        end
        checks++;
        if (!ok || imem_addr !== 64'h8000_0100) begin
            errors++;
            $display("FAIL rw_target: got %b/%h want 1/%h",
                     ok, imem_addr, 64'h8000_0100);
        end
    endtask

    task automatic test_redirect_rvalid();
        bit found;
        if_ready   = 1'b1;
        imem_ready = 1'b1;
        mem_lat    = 1;
        found      = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = imem_rvalid;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rr_no_rvalid: got none want rvalid");
        end
        redirect    = 1'b1;
        redirect_pc = 64'h8000_2000;
        #1;
        checks++;
        if (imem_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_suppress: got %b want 0", imem_valid);
        end
        step();
        redirect = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_push: got %b want 0", if_valid);
        end
        checks++;
        if (imem_valid !== 1'b1 || imem_addr !== 64'h8000_2000) begin
            errors++;
            $display("FAIL rr_target: got %b/%h want 1/%h",
                     imem_valid, imem_addr, 64'h8000_2000);
        end
    endtask

    task automatic test_wrap();
        bit hit;
        if_ready    = 1'b1;
        imem_ready  = 1'b1;
        mem_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
        step();
        redirect = 1'b0;
        hit      = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            hit = imem_valid && imem_addr == 64'd0;
            step();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wrap_addr: got no request to 0 want one");
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            imem_ready = ($urandom_range(99) < 70);
            if_ready   = ($urandom_range(99) < 55);
            mem_lat    = $urandom_range(3, 1);
            redirect   = ($urandom_range(99) < 4);
            if ($urandom_range(3) == 0)
                redirect_pc = {32'hFFFF_FFFF, $urandom()};
            else
                redirect_pc = {32'h0, 4'h8, $urandom_range(4095), 2'b00}
                              | 64'($urandom_range(3));
            step();
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        if_ready   = 1'b1;
        imem_ready = 1'b1;
        mem_auto   = 0;
        p_v        = 0;
        imem_rvalid = 1'b0;
        found      = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            found = imem_valid;
            step();
        end
        rst = 1'b1;
        step();
        rst         = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_late_ignored: got %b want 0", if_valid);
        end
        checks++;
        if (imem_valid !== 1'b1 || imem_addr !== RV) begin
            errors++;
            $display("FAIL rm_restart: got %b/%h want 1/%h",
                     imem_valid, imem_addr, RV);
        end
        mem_auto   = 1;
        imem_ready = 1'b1;
        mem_lat    = 1;
        pops.delete();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (pops.size() == 0 || pops[0] !== RV) begin
            errors++;
            $display("FAIL rm_first_pc: got %h want %h",
                     pops.size() ? pops[0] : 64'hX, RV);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;
        mem_auto    = 1;
        mem_lat     = 1;
        p_v         = 0;
        p_cnt       = 0;
        p_addr      = '0;
        m_fetch     = RV;
        m_out       = 0;
        m_drop      = 0;
        m_out_pc    = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_push_pop();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
